// File: rtl/aes_req_sched.sv
// AES request scheduler: loads a key into the AES core, arbitrates two
// requesters round-robin onto the encrypt and decrypt pipes under per-direction
// credit limits, and returns results tagged with the originating requester.
module aes_req_sched #(
    parameter int unsigned MAX_INFLIGHT = 12
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,

    input  logic         req0_valid,
    input  logic         req0_op,
    input  logic [127:0] req0_block,
    output logic         req0_ready,

    input  logic         req1_valid,
    input  logic         req1_op,
    input  logic [127:0] req1_block,
    output logic         req1_ready,

    output logic         core_reset_key,
    output logic [127:0] core_key,
    input  logic         core_ready_key,

    output logic         core_reset_enc,
    output logic         core_reset_dec,
    output logic [127:0] core_block_enc,
    output logic [127:0] core_block_dec,

    input  logic         core_oready_enc,
    input  logic         core_oready_dec,
    input  logic [127:0] core_result_enc,
    input  logic [127:0] core_result_dec,

    output logic         rsp_enc_valid,
    output logic         rsp_dec_valid,
    output logic         rsp_enc_id,
    output logic         rsp_dec_id,
    output logic [127:0] rsp_enc_data,
    output logic [127:0] rsp_dec_data,

    output logic         err
);

    typedef enum logic [2:0] {
        NOKEY,
        KEY_ISSUE,
        KEY_WAIT,
        RUN,
        DRAIN
    } state_t;

    localparam logic [3:0] CREDIT_MAX = 4'(MAX_INFLIGHT);

    state_t       state;
    logic         rr_ptr;      // 0: req0 preferred on a tie, 1: req1 preferred
    logic         issue_open;
    logic         elig0;
    logic         elig1;
    logic         accept;
    logic         win_id;
    logic         win_op;
    logic [127:0] win_block;
    logic [1:0]   credit_ok;
    logic         drained;
    logic         key_hs;

    // Per-direction views of the core return ports (index 0 = enc, 1 = dec)
    logic [1:0]   oready_v;
    logic [127:0] result_v [2];

    assign oready_v    = {core_oready_dec, core_oready_enc};
    assign result_v[0] = core_result_enc;
    assign result_v[1] = core_result_dec;

    // Round-robin arbitration between eligible requesters; a pending key
    // change in RUN shuts off issue in the same cycle it is seen
    always_comb begin
        issue_open = (state == RUN) && !key_valid;
        elig0      = issue_open && req0_valid && credit_ok[req0_op];
        elig1      = issue_open && req1_valid && credit_ok[req1_op];
        req0_ready = elig0 && (!elig1 || !rr_ptr);
        req1_ready = elig1 && (!elig0 || rr_ptr);
        accept     = req0_ready || req1_ready;
        win_id     = req1_ready;
        win_op     = req1_ready ? req1_op : req0_op;
        win_block  = req1_ready ? req1_block : req0_block;
    end

    // One tag FIFO, in-flight counter and response register per direction.
    // The counter doubles as FIFO occupancy: both move on the same push/pop.
    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [3:0]   cnt;
        logic [3:0]   wr_ptr;
        logic [3:0]   rd_ptr;
        logic [15:0]  ids;
        logic         empty;
        logic         push;
        logic         pop;
        logic         rsp_valid;
        logic         rsp_id;
        logic [127:0] rsp_data;

        assign push  = accept && (win_op == 1'(d));
        assign empty = (cnt == '0);
        assign pop   = oready_v[d] && !empty;

        // Tag push on accept, tag pop plus registered response on core return
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt       <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                ids       <= '0;
                rsp_valid <= 1'b0;
                rsp_id    <= 1'b0;
                rsp_data  <= '0;
            end else begin
                rsp_valid <= pop;
                if (pop) begin
                    rsp_id   <= ids[rd_ptr];
                    rsp_data <= result_v[d];
                    rd_ptr   <= rd_ptr + 4'd1;
                end
                if (push) begin
                    ids[wr_ptr] <= win_id;
                    wr_ptr      <= wr_ptr + 4'd1;
                end
                if (push && !pop) begin
                    cnt <= cnt + 4'd1;
                end else if (pop && !push) begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    assign credit_ok[0] = g_dir[0].cnt < CREDIT_MAX;
    assign credit_ok[1] = g_dir[1].cnt < CREDIT_MAX;

    assign rsp_enc_valid = g_dir[0].rsp_valid;
    assign rsp_enc_id    = g_dir[0].rsp_id;
    assign rsp_enc_data  = g_dir[0].rsp_data;
    assign rsp_dec_valid = g_dir[1].rsp_valid;
    assign rsp_dec_id    = g_dir[1].rsp_id;
    assign rsp_dec_data  = g_dir[1].rsp_data;

    // Key acceptance: idle with no key, or draining with nothing left in flight
    always_comb begin
        drained   = g_dir[0].empty && g_dir[1].empty;
        key_ready = !reset && ((state == NOKEY) || ((state == DRAIN) && drained));
        key_hs    = key_valid && key_ready;
    end

    // Key-load / run / drain sequencing with the registered key-start pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= NOKEY;
            core_reset_key <= 1'b0;
            core_key       <= '0;
        end else begin
            core_reset_key <= 1'b0;
            case (state)
                NOKEY, DRAIN: begin
                    if (key_hs) begin
                        core_key       <= key;
                        core_reset_key <= 1'b1;
                        state          <= KEY_ISSUE;
                    end
                end
                KEY_ISSUE: begin
                    state <= KEY_WAIT;
                end
                KEY_WAIT: begin
                    if (core_ready_key) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (key_valid) begin
                        state <= DRAIN;
                    end
                end
                default: begin
                    state <= NOKEY;
                end
            endcase
        end
    end

    // Issue pulse and block register per direction, one cycle after accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset_enc <= 1'b0;
            core_reset_dec <= 1'b0;
            core_block_enc <= '0;
            core_block_dec <= '0;
        end else begin
            core_reset_enc <= g_dir[0].push;
            core_reset_dec <= g_dir[1].push;
            if (g_dir[0].push) begin
                core_block_enc <= win_block;
            end
            if (g_dir[1].push) begin
                core_block_dec <= win_block;
            end
        end
    end

    // Round-robin pointer moves past each winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= !win_id;
        end
    end

    // Sticky protocol error: a core result arriving with no tag outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= err || (oready_v[0] && g_dir[0].empty) || (oready_v[1] && g_dir[1].empty);
        end
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// Bench for aes_req_sched: directed key/arbitration/credit/rekey/reset steps
// plus randomized traffic, checked against a queue-based reference model.
module tb_aes_req_sched;

    localparam int MAXF = 12;
    localparam int PH_NOKEY = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_DRAIN = 4;
    localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         reset;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         req0_valid, req0_op, req0_ready;
    logic [127:0] req0_block;
    logic         req1_valid, req1_op, req1_ready;
    logic [127:0] req1_block;
    logic         core_reset_key;
    logic [127:0] core_key;
    logic         core_ready_key;
    logic         core_reset_enc, core_reset_dec;
    logic [127:0] core_block_enc, core_block_dec;
    logic         core_oready_enc, core_oready_dec;
    logic [127:0] core_result_enc, core_result_dec;
    logic         rsp_enc_valid, rsp_dec_valid, rsp_enc_id, rsp_dec_id;
    logic [127:0] rsp_enc_data, rsp_dec_data;
    logic         err;

    aes_req_sched #(.MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key(key), .key_ready(key_ready),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_block(req0_block), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_block(req1_block), .req1_ready(req1_ready),
        .core_reset_key(core_reset_key), .core_key(core_key), .core_ready_key(core_ready_key),
        .core_reset_enc(core_reset_enc), .core_reset_dec(core_reset_dec),
        .core_block_enc(core_block_enc), .core_block_dec(core_block_dec),
        .core_oready_enc(core_oready_enc), .core_oready_dec(core_oready_dec),
        .core_result_enc(core_result_enc), .core_result_dec(core_result_dec),
        .rsp_enc_valid(rsp_enc_valid), .rsp_dec_valid(rsp_dec_valid),
        .rsp_enc_id(rsp_enc_id), .rsp_dec_id(rsp_dec_id),
        .rsp_enc_data(rsp_enc_data), .rsp_dec_data(rsp_dec_data),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: outstanding requester IDs per direction, scheduler phase,
    // round-robin preference, sticky error
    int enc_q[$];
    int dec_q[$];
    int m_phase;
    bit m_pref;
    bit m_err;
    int grant_log[$];
    int rsp_log[$];
    int exp_ord[4] = '{0, 1, 0, 1};

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int inflight(input logic op);
        return op ? dec_q.size() : enc_q.size();
    endfunction

    task automatic model_reset();
        enc_q.delete();
        dec_q.delete();
        m_phase = PH_NOKEY;
        m_pref  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_key_ready"}, key_ready, 1'b0);
        chk1({tag, "_req0_ready"}, req0_ready, 1'b0);
        chk1({tag, "_req1_ready"}, req1_ready, 1'b0);
        chk1({tag, "_core_reset_key"}, core_reset_key, 1'b0);
        chk128({tag, "_core_key"}, core_key, '0);
        chk1({tag, "_core_reset_enc"}, core_reset_enc, 1'b0);
        chk1({tag, "_core_reset_dec"}, core_reset_dec, 1'b0);
        chk128({tag, "_core_block_enc"}, core_block_enc, '0);
        chk128({tag, "_core_block_dec"}, core_block_dec, '0);
        chk1({tag, "_rsp_enc_valid"}, rsp_enc_valid, 1'b0);
        chk1({tag, "_rsp_dec_valid"}, rsp_dec_valid, 1'b0);
        chk1({tag, "_rsp_enc_id"}, rsp_enc_id, 1'b0);
        chk1({tag, "_rsp_dec_id"}, rsp_dec_id, 1'b0);
        chk128({tag, "_rsp_enc_data"}, rsp_enc_data, '0);
        chk128({tag, "_rsp_dec_data"}, rsp_dec_data, '0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    // One clock cycle: inputs are already driven (posedge+1); check the
    // combinational readies, predict the registered outputs, advance the model,
    // cross the edge and check the predictions.
    task automatic tick();
        bit exp_kr, e0, e1, g0, g1, hs, pop_e, pop_d, win, wop;
        logic [127:0] wblk, res_e, res_d, key_s;
        int id_e, id_d;
        core_result_enc = rnd128();
        core_result_dec = rnd128();
        #1;
        exp_kr = (m_phase == PH_NOKEY) ||
                 ((m_phase == PH_DRAIN) && (enc_q.size() == 0) && (dec_q.size() == 0));
        chk1("key_ready", key_ready, exp_kr);
        e0 = (m_phase == PH_RUN) && !key_valid && req0_valid && (inflight(req0_op) < MAXF);
        e1 = (m_phase == PH_RUN) && !key_valid && req1_valid && (inflight(req1_op) < MAXF);
        if (e0 && e1) begin
            g0 = !m_pref;
            g1 = m_pref;
        end else begin
            g0 = e0;
            g1 = e1;
        end
        chk1("req0_ready", req0_ready, g0);
        chk1("req1_ready", req1_ready, g1);
        if (req0_ready) grant_log.push_back(0);
        else if (req1_ready) grant_log.push_back(1);
        win   = g1;
        wop   = g1 ? req1_op : req0_op;
        wblk  = g1 ? req1_block : req0_block;
        hs    = key_valid && exp_kr;
        key_s = key;
        res_e = core_result_enc;
        res_d = core_result_dec;
        pop_e = 1'b0; id_e = 0;
        pop_d = 1'b0; id_d = 0;
        if (core_oready_enc) begin
            if (enc_q.size() > 0) begin pop_e = 1'b1; id_e = enc_q.pop_front(); end
            else m_err = 1'b1;
        end
        if (core_oready_dec) begin
            if (dec_q.size() > 0) begin pop_d = 1'b1; id_d = dec_q.pop_front(); end
            else m_err = 1'b1;
        end
        if (g0 || g1) begin
            if (wop) dec_q.push_back(int'(win));
            else enc_q.push_back(int'(win));
            m_pref = !win;
        end
        case (m_phase)
            PH_NOKEY: if (hs) m_phase = PH_ISSUE;
            PH_ISSUE: m_phase = PH_WAIT;
            PH_WAIT:  if (core_ready_key) m_phase = PH_RUN;
            PH_RUN:   if (key_valid) m_phase = PH_DRAIN;
            PH_DRAIN: if (hs) m_phase = PH_ISSUE;
            default: ;
        endcase
        @(posedge clk);
        #1;
        chk1("core_reset_key", core_reset_key, hs);
        if (hs) chk128("core_key", core_key, key_s);
        chk1("core_reset_enc", core_reset_enc, (g0 || g1) && !wop);
        if ((g0 || g1) && !wop) chk128("core_block_enc", core_block_enc, wblk);
        chk1("core_reset_dec", core_reset_dec, (g0 || g1) && wop);
        if ((g0 || g1) && wop) chk128("core_block_dec", core_block_dec, wblk);
        chk1("rsp_enc_valid", rsp_enc_valid, pop_e);
        if (pop_e) begin
            chkint("rsp_enc_id", int'(rsp_enc_id), id_e);
            chk128("rsp_enc_data", rsp_enc_data, res_e);
        end
        chk1("rsp_dec_valid", rsp_dec_valid, pop_d);
        if (pop_d) begin
            chkint("rsp_dec_id", int'(rsp_dec_id), id_d);
            chk128("rsp_dec_data", rsp_dec_data, res_d);
        end
        chk1("err", err, m_err);
        if (rsp_enc_valid) rsp_log.push_back(int'(rsp_enc_id));
    endtask

    task automatic drain_all();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 40 && (enc_q.size() > 0 || dec_q.size() > 0); i++) begin
            core_oready_enc = (enc_q.size() > 0);
            core_oready_dec = (dec_q.size() > 0);
            tick();
        end
        core_oready_enc = 1'b0;
        core_oready_dec = 1'b0;
    endtask

    task automatic one_req(input bit who, input bit op);
        req0_valid = !who; req0_op = op; req0_block = rnd128();
        req1_valid = who;  req1_op = op; req1_block = rnd128();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        key_valid = 1'b0; key = '0; core_ready_key = 1'b0;
        req0_valid = 1'b0; req0_op = 1'b0; req0_block = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_block = '0;
        core_oready_enc = 1'b0; core_oready_dec = 1'b0;
        core_result_enc = '0; core_result_dec = '0;
        model_reset();

        // Reset state, including readies held low with requests driven
        @(posedge clk); #1;
        chk_zero("rst");
        key_valid = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk_zero("rst_drv");
        key_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Key load; ready already high during KEY_ISSUE must not short-cut it
        key_valid = 1'b1; key = KEY0;
        tick();
        key_valid = 1'b0;
        core_ready_key = 1'b1;
        tick();
        tick();
        core_ready_key = 1'b0;

        // Arbitration: both requesters encrypting for 4 cycles
        grant_log.delete();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 1'b0; req1_op = 1'b0;
        repeat (4) begin
            req0_block = rnd128();
            req1_block = rnd128();
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chkint("arb_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chkint("arb_order", grant_log[i], exp_ord[i]);
        rsp_log.delete();
        drain_all();
        chkint("rsp_count", rsp_log.size(), 4);
        for (int i = 0; i < 4 && i < rsp_log.size(); i++) chkint("rsp_id_order", rsp_log[i], exp_ord[i]);

        // Credit limit: 16 cycles of enc requests with no returns
        grant_log.delete();
        req0_valid = 1'b1; req0_op = 1'b0; req0_block = rnd128();
        for (int i = 0; i < 16; i++) begin
            n = grant_log.size();
            tick();
            if (grant_log.size() != n) req0_block = rnd128();
        end
        chkint("credit_issued", grant_log.size(), MAXF);
        core_oready_enc = 1'b1;
        tick();
        core_oready_enc = 1'b0;
        chkint("credit_hold", grant_log.size(), MAXF);
        tick();
        chkint("credit_resume", grant_log.size(), MAXF + 1);
        drain_all();

        // Simultaneous enc/dec return
        one_req(1'b0, 1'b0);
        one_req(1'b1, 1'b1);
        core_oready_enc = 1'b1; core_oready_dec = 1'b1;
        tick();
        core_oready_enc = 1'b0; core_oready_dec = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_op = 1'($urandom_range(0, 1));
            req1_op = 1'($urandom_range(0, 1));
            req0_block = rnd128();
            req1_block = rnd128();
            core_oready_enc = (enc_q.size() > 0) && ($urandom_range(0, 3) == 0);
            core_oready_dec = (dec_q.size() > 0) && ($urandom_range(0, 3) == 0);
            tick();
        end
        drain_all();

        // Rekey with three operations in flight
        one_req(1'b0, 1'b0);
        one_req(1'b1, 1'b0);
        one_req(1'b0, 1'b1);
        key_valid = 1'b1; key = rnd128();
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        core_oready_enc = 1'b1; tick(); tick(); core_oready_enc = 1'b0;
        core_oready_dec = 1'b1; tick(); core_oready_dec = 1'b0;
        for (int i = 0; i < 10 && m_phase != PH_ISSUE; i++) tick();
        key_valid = 1'b0;
        chk1("rekey_pulse", core_reset_key, 1'b1);
        core_ready_key = 1'b1;
        tick();
        tick();
        core_ready_key = 1'b0;

        // Reset with five in flight, then a stale result
        one_req(1'b0, 1'b0);
        one_req(1'b1, 1'b0);
        one_req(1'b0, 1'b0);
        one_req(1'b1, 1'b1);
        one_req(1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        chk_zero("midrst_hold");
        reset = 1'b0;
        core_oready_enc = 1'b1;
        tick();
        core_oready_enc = 1'b0;
        tick();
        chk1("final_err", err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_req_sched.md
AES_REQ_SCHED -- requirements
Module: aes_req_sched

Interface
REQ-001 Parameter: MAX_INFLIGHT, default 12, maximum outstanding operations per direction (enc and dec counted separately); range 1..15.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 key_valid  in  1  new 128-bit key offered.
REQ-005 key  in  128  key value; sampled when key_valid & key_ready.
REQ-006 key_ready  out  1  scheduler accepts a key this cycle.
REQ-007 reqN_valid  in  1  request from requester N (N = 0, 1).
REQ-008 reqN_op  in  1  0 = encrypt, 1 = decrypt.
REQ-009 reqN_block  in  128  data block.
REQ-010 reqN_ready  out  1  request accepted when valid & ready.
REQ-011 core_reset_key  out  1  one-cycle key-expansion start pulse to the core.
REQ-012 core_key  out  128  registered key to the core.
REQ-013 core_ready_key  in  1  key expansion complete.
REQ-014 core_reset_enc / core_reset_dec  out  1 each  one-cycle issue pulse per direction.
REQ-015 core_block_enc / core_block_dec  out  128 each  registered issue block.
REQ-016 core_oready_enc / core_oready_dec  in  1 each  result-valid pulse from the core.
REQ-017 core_result_enc / core_result_dec  in  128 each  core result data.
REQ-018 rsp_enc_valid / rsp_dec_valid  out  1 each  one-cycle response pulse; no backpressure.
REQ-019 rsp_enc_id / rsp_dec_id  out  1 each  originating requester.
REQ-020 rsp_enc_data / rsp_dec_data  out  128 each  result block.

Function
REQ-021 FSM states: NOKEY, KEY_ISSUE, KEY_WAIT, RUN, DRAIN.
REQ-022 NOKEY: key_ready = 1, reqN_ready = 0; a key handshake -> KEY_ISSUE.
REQ-023 KEY_ISSUE: core_reset_key = 1 for exactly one cycle -> KEY_WAIT.
REQ-024 KEY_WAIT: requests are blocked; core_ready_key = 1 -> RUN; the ready signal is not sampled in the KEY_ISSUE cycle.
REQ-025 RUN: key_ready = 0 once key_valid is seen; key_valid = 1 -> DRAIN and no further issues.
REQ-026 DRAIN: issue blocked; when both in-flight counters reach 0, key_ready = 1; on key handshake -> KEY_ISSUE.
REQ-027 Arbitration: at most one request is issued per cycle, chosen by round-robin between eligible requesters; the pointer advances past the winner; after reset the pointer favours req0.
REQ-028 A requester is eligible when state = RUN, reqN_valid = 1, and the in-flight counter for its op direction < MAX_INFLIGHT.
REQ-029 Issue: on the cycle after acceptance, core_reset_<dir> = 1 for one cycle and core_block_<dir> holds the accepted block.
REQ-030 reqN_ready is combinational: 1 only for the arbitration winner in that cycle.
REQ-031 Tag tracking: each direction has a 16-entry, in-order ID FIFO; the requester ID is pushed on issue and popped on core_oready_<dir>.
REQ-032 Response: on core_oready_<dir> = 1, rsp_<dir>_valid = 1 in the next cycle with the registered core_result_<dir> and the popped ID.
REQ-033 Enc and dec responses in the same cycle are both emitted with no ordering dependency.
REQ-034 In-flight counter: +1 on issue, -1 on oready, unchanged when both occur in the same cycle; 4-bit; never wraps.
REQ-035 core_oready_<dir> with an empty FIFO (protocol error): the response is suppressed, the counter holds at 0, and the sticky err output is set.
REQ-036 err  out  1  sticky protocol-error flag, cleared only by reset.

Reset
REQ-037 reset asserted, at any time: state -> NOKEY, FIFOs emptied, counters = 0, RR pointer -> req0, err = 0.
REQ-038 While reset is asserted, all pulse outputs, valids and readies = 0 and data outputs = 0.
REQ-039 Results returning after a mid-operation reset are treated as protocol errors (REQ-035).

Verification
REQ-040 Key load: key_valid with key = 0x2b7e1516_28aed2a6_abf71588_09cf4f3c -> core_reset_key pulse 1 cycle later; core_ready_key -> RUN, req0_ready asserted.
REQ-041 Arbitration: req0 and req1 both valid for 4 cycles, both enc -> accept order 0,1,0,1; rsp_enc_id sequence 0,1,0,1 in core return order.
REQ-042 Credit limit: MAX_INFLIGHT = 12, 13 enc requests with no oready -> 12 issued, 13th held with ready = 0 until the first oready.
REQ-043 Simultaneous return: enc and dec oready in the same cycle -> both rsp valids 1 cycle later with correct IDs and data.
REQ-044 Rekey: key_valid with 3 ops in flight -> no issues, key_ready = 0 until 3 responses return, then key accepted and KEY_ISSUE entered.
REQ-045 Reset mid-flight: reset with 5 in flight, then a spurious oready -> no rsp_valid, err = 1, state NOKEY.
